// File: rtl/tff_cnt_pkg.sv
`default_nettype none
// ============================================================================
// Package     : tff_cnt_pkg
// Description : Shared constants and helpers for the T-flip-flop up/down
//               counter (direction encodings, terminal-count computation).
//               Optional macro TFF_CNT_MOD_EN selects a MOD-based modulus.
// Revision    : 1.0 - initial release
// ============================================================================
package tff_cnt_pkg;

    localparam logic CNT_UP = 1'b1;
    localparam logic CNT_DN = 1'b0;

    // Highest value the counter reaches before wrapping.
    function automatic int cnt_top(input int width, input int mod);
`ifdef TFF_CNT_MOD_EN
        return mod - 1;
`else
        // Natural-modulus build: mod does not affect the result.
        return (mod * 0) + ((1 << width) - 1);
`endif
    endfunction

endpackage
`default_nettype wire

// File: rtl/tff_cell.sv
`default_nettype none
// ============================================================================
// Module      : tff_cell
// Description : Single T flip-flop storage cell with asynchronous clear and
//               synchronous parallel load (load has priority over toggle).
// Ports       : clk   - rising-edge clock
//               rst_n - asynchronous active-low clear
//               t     - toggle enable
//               ld    - synchronous load
//               d     - load data
//               q     - registered cell output
// Revision    : 1.0 - initial release
// ============================================================================
module tff_cell (
    input  logic clk,
    input  logic rst_n,
    input  logic t,
    input  logic ld,
    input  logic d,
    output logic q
);

    logic r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= 1'b0;
        end else if (ld) begin
            r_q <= d;
        end else if (t) begin
            r_q <= ~r_q;
        end
    end

    assign q = r_q;

endmodule
`default_nettype wire

// File: rtl/tff_sync_counter.sv
`default_nettype none
// ============================================================================
// Module      : tff_sync_counter
// Description : Synchronous up/down binary counter built from WIDTH tff_cell
//               instances. Per-bit toggle enables are formed combinationally.
//               Optional macro TFF_CNT_MOD_EN: counts modulo MOD and saturates
//               loads at MOD-1; otherwise counts modulo 2**WIDTH.
// Ports       : clk      - rising-edge clock
//               rst_n    - asynchronous active-low reset
//               en       - count enable
//               up       - direction (1 = up, 0 = down)
//               load     - synchronous parallel load (beats en)
//               load_val - value loaded when load = 1
//               q        - registered counter value
//               tc       - combinational terminal count
//               wrap     - registered one-cycle pulse after a wrap
// Revision    : 1.0 - initial release
// ============================================================================
module tff_sync_counter
    import tff_cnt_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int MOD   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] c_TOP  = WIDTH'(cnt_top(WIDTH, MOD));
    localparam logic [WIDTH-1:0] c_ZERO = '0;

    logic [WIDTH-1:0] w_q;
    logic [WIDTH-1:0] w_t_up;
    logic [WIDTH-1:0] w_t_dn;
    logic [WIDTH-1:0] w_t_nat;
    logic [WIDTH-1:0] w_t;
    logic [WIDTH-1:0] w_ld_val;
    logic             w_cnt;
    logic             w_at_top;
    logic             w_at_zero;
    logic             r_wrap;

    // Bit i toggles when all lower bits are 1 (up) or all 0 (down).
    assign w_t_up[0] = 1'b1;
    assign w_t_dn[0] = 1'b1;
    for (genvar i = 1; i < WIDTH; i++) begin : g_tvec
        assign w_t_up[i] = &w_q[i-1:0];
        assign w_t_dn[i] = &(~w_q[i-1:0]);
    end

    assign w_t_nat   = (up == CNT_UP) ? w_t_up : w_t_dn;
    assign w_at_top  = (w_q == c_TOP);
    assign w_at_zero = (w_q == c_ZERO);

`ifdef TFF_CNT_MOD_EN
    // At the modulus boundary the toggle vector is chosen so that q ^ T
    // lands on 0 (going up from TOP) or on TOP (going down from 0).
    always_comb begin
        w_t = w_t_nat;
        if ((up == CNT_UP) && w_at_top) begin
            w_t = w_q;
        end else if ((up == CNT_DN) && w_at_zero) begin
            w_t = c_TOP;
        end
    end
    assign w_ld_val = (32'(load_val) >= MOD) ? c_TOP : load_val;
`else
    assign w_t      = w_t_nat;
    assign w_ld_val = load_val;
`endif

    // Counting only happens when enabled and not overridden by a load.
    assign w_cnt = en & ~load;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        tff_cell u_cell (
            .clk   (clk),
            .rst_n (rst_n),
            .t     (w_cnt & w_t[i]),
            .ld    (load),
            .d     (w_ld_val[i]),
            .q     (w_q[i])
        );
    end

    assign tc = w_cnt & ((up == CNT_UP) ? w_at_top : w_at_zero);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wrap <= 1'b0;
        end else begin
            r_wrap <= tc;
        end
    end

    assign q    = w_q;
    assign wrap = r_wrap;

endmodule
`default_nettype wire

// File: tb/tb_tff_sync_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_tff_sync_counter
// Description : Scoreboard testbench for tff_sync_counter (WIDTH = 4).
//               Define TFF_CNT_MOD_EN to exercise the MOD = 10 build.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tff_sync_counter;

    localparam int c_WIDTH = 4;
`ifdef TFF_CNT_MOD_EN
    localparam int c_MOD = 10;
`else
    localparam int c_MOD = 16;
`endif

    logic               clk;
    logic               rst_n;
    logic               en;
    logic               up;
    logic               load;
    logic [c_WIDTH-1:0] load_val;
    logic [c_WIDTH-1:0] q;
    logic               tc;
    logic               wrap;

    tff_sync_counter #(.WIDTH(c_WIDTH), .MOD(c_MOD)) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .up       (up),
        .load     (load),
        .load_val (load_val),
        .q        (q),
        .tc       (tc),
        .wrap     (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       tc;
        logic [3:0] q;
        logic       wrap;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   m_q      = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // One stimulus cycle: drive inputs, predict the response from the
    // counting rules, push the prediction for the monitor.
    task automatic step(input logic i_en, input logic i_up, input logic i_ld,
                        input int i_lv);
        exp_t e;
        int   nq;
        @(negedge clk);
        en       = i_en;
        up       = i_up;
        load     = i_ld;
        load_val = 4'(i_lv);
        e.tc = i_en && !i_ld && (i_up ? (m_q == c_MOD - 1) : (m_q == 0));
        if (i_ld)       nq = (i_lv >= c_MOD) ? c_MOD - 1 : i_lv;
        else if (i_en)  nq = i_up ? (m_q + 1) % c_MOD : (m_q + c_MOD - 1) % c_MOD;
        else            nq = m_q;
        e.q    = 4'(nq);
        e.wrap = e.tc;
        sb.push_back(e);
        m_q = nq;
    endtask

    task automatic drain();
        int budget = 10;
        while (sb.size() != 0 && budget > 0) begin
            @(posedge clk);
            #2;
            budget--;
        end
        if (sb.size() != 0) chk("drain_timeout", sb.size(), 0);
    endtask

    // Monitor: tc sampled mid-cycle after inputs settle, q/wrap after the edge.
    logic r_tc_s;
    initial begin
        r_tc_s = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            r_tc_s = tc;
            @(posedge clk);
            #1;
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                chk("tc",   int'(r_tc_s), int'(e.tc));
                chk("q",    int'(q),      int'(e.q));
                chk("wrap", int'(wrap),   int'(e.wrap));
            end
        end
    end

    initial begin
        rst_n    = 1'b0;
        en       = 1'b0;
        up       = 1'b1;
        load     = 1'b0;
        load_val = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_q",    int'(q),    0);
        chk("reset_wrap", int'(wrap), 0);
        rst_n = 1'b1;

        // Asynchronous reset between edges, overriding en.
        repeat (5) step(1'b1, 1'b1, 1'b0, 0);
        drain();
        chk("pre_reset_q", int'(q), 5);
        en = 1'b1;
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_q",    int'(q),    0);
        chk("async_wrap", int'(wrap), 0);
        repeat (2) begin
            @(posedge clk);
            #1;
            chk("held_q",    int'(q),    0);
            chk("held_wrap", int'(wrap), 0);
        end
        @(negedge clk);
        en    = 1'b0;
        rst_n = 1'b1;
        m_q   = 0;

        // Full up sweep through the wrap, then down through zero.
        repeat (c_MOD + 1) step(1'b1, 1'b1, 1'b0, 0);
        step(1'b1, 1'b1, 1'b1, 0);
        repeat (3) step(1'b1, 1'b0, 1'b0, 0);

        // Load beats en, then hold.
        step(1'b0, 1'b1, 1'b1, 3);
        step(1'b1, 1'b1, 1'b1, 'hA);
        repeat (3) step(1'b0, 1'b1, 1'b0, 0);

        // Direction change takes effect on the same edge.
        step(1'b0, 1'b1, 1'b1, 7);
        step(1'b1, 1'b0, 1'b0, 0);
        step(1'b1, 1'b1, 1'b0, 0);

        // Modulus boundary and load saturation (natural wrap when undefined).
        step(1'b0, 1'b1, 1'b1, 8);
        repeat (2) step(1'b1, 1'b1, 1'b0, 0);
        step(1'b1, 1'b0, 1'b0, 0);
        step(1'b0, 1'b1, 1'b1, 'hC);
        step(1'b0, 1'b1, 1'b1, 'hF);

        // Randomised traffic.
        for (int k = 0; k < 300; k++) begin
            step(1'($urandom_range(0, 3) != 0), 1'($urandom),
                 1'($urandom_range(0, 7) == 0), int'($urandom_range(0, 15)));
        end
        @(negedge clk);
        en   = 1'b0;
        load = 1'b0;
        drain();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
